mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter STREAK_MAX, default 4, max consecutive contested data grants before a forced instruction grant.
REQ-004 Parameter TIMEOUT, default 16, max BUSY cycles awaiting m_ack.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 i_req  in  1  instruction-fetch request; i_addr  in  ADDR_W  fetch address.
REQ-008 i_rdata  out  DATA_W  fetched word; i_wait  out  1  stall; i_fault  out  1  fetch timed out.
REQ-009 d_req  in  1  data request; d_we  in  1  write enable; d_addr  in  ADDR_W; d_wdata  in  DATA_W.
REQ-010 d_rdata  out  DATA_W; d_wait  out  1; d_fault  out  1.
REQ-011 m_req  out  1; m_we  out  1; m_addr  out  ADDR_W; m_wdata  out  DATA_W; m_rdata  in  DATA_W; m_ack  in  1  (shared memory port).

Function
REQ-012 States: IDLE, BUSY, RESP; grant register G in {INSTR, DATA}.
REQ-013 IDLE: no request -> stay; otherwise latch G, address, we, wdata of winner -> BUSY next cycle.
REQ-014 Arbitration: only one requesting -> it wins; both -> DATA wins unless streak == STREAK_MAX, then INSTR wins.
REQ-015 Streak: +1 (saturating) when DATA wins while i_req=1; cleared when INSTR is granted or when DATA is granted with i_req=0.
REQ-016 m_req=1 exactly while in BUSY; m_addr/m_we/m_wdata are registered values, stable throughout BUSY; m_we=0 for INSTR grants.
REQ-017 BUSY: m_ack=1 -> capture m_rdata (reads only), fault=0, -> RESP.
REQ-018 BUSY timer cleared on BUSY entry, +1 per BUSY cycle without m_ack; no ack in the TIMEOUT-th BUSY cycle -> RESP with fault=1, rdata=0; ack in that cycle wins (no fault).
REQ-019 m_ack outside BUSY is ignored.
REQ-020 RESP lasts one cycle; granted side gets rdata and fault for that cycle; -> IDLE.
REQ-021 i_wait = i_req AND NOT (RESP AND G=INSTR); d_wait likewise for DATA; non-granted side never sees wait low while requesting.
REQ-022 i_rdata/d_rdata and faults hold value until the next RESP for the same side; faults valid only in RESP cycle.
REQ-023 Requester holds req/addr/data stable until its wait-low cycle; req held high after RESP is a new transaction, re-arbitrated in IDLE.
REQ-024 Req dropped mid-transaction: transaction still completes; RESP still occurs; wait already low.
REQ-025 Minimum latency: req in IDLE cycle N, m_req at N+1, ack at N+1, wait low at N+2; back-to-back grant earliest m_req at N+4.
REQ-026 Write transactions: rdata register for DATA unchanged (holds previous value).

Reset
REQ-027 rst_n=0 at clock edge: state IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, timer=0, streak=0, i_rdata=d_rdata=0, faults=0.
REQ-028 Reset mid-BUSY aborts without RESP; m_req low the cycle after reset edge.
REQ-029 While rst_n=0, i_wait/d_wait equal their req inputs.

Structure
REQ-030 Shared package rapids_mem_pkg holds state enum, grant enum, and default ADDR_W/DATA_W.
REQ-031 Single module; no sub-module; all registered outputs.

Verification
REQ-032 Single read: i_req=1,i_addr=0x100; m_ack one cycle after m_req with m_rdata=0xDEADBEEF -> i_wait low 2 cycles after req edge, i_rdata=0xDEADBEEF, i_fault=0.
REQ-033 Contention: i_req,d_req held high, ack immediate -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-034 Timeout: d_req=1, m_ack never -> m_req high exactly 16 cycles, d_fault=1 one cycle, d_rdata=0, return to IDLE.
REQ-035 Late ack: ack on 16th BUSY cycle -> no fault, data captured; spurious m_ack in IDLE -> no state change.
REQ-036 Write: d_we=1,d_addr=0x40,d_wdata=0x1234 -> m_we=1,m_addr=0x40,m_wdata=0x1234 stable until ack; d_rdata unchanged.
REQ-037 Reset mid-BUSY: rst_n=0 for one edge -> m_req=0 next cycle, streak=0, no RESP pulse.

Source files
------------

// File: rtl/rapids_mem_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant owner
// and default bus widths.
package rapids_mem_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
    typedef enum logic       {G_INSTR, G_DATA}           grant_t;
endpackage

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto one shared memory port.
// Data has priority, but a run of contested data grants forces an instruction grant.
module mem_arbiter
    import rapids_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_wait,
    output logic              i_fault,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_wait,
    output logic              d_fault,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);
    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            r_state;
    grant_t            r_grant;
    logic [SW-1:0]     r_streak;
    logic [TW-1:0]     r_timer;
    logic              r_m_req;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_fault;
    logic              r_d_fault;

    logic w_pick_d;
    logic w_streak_full;
    logic w_resp_i;
    logic w_resp_d;

    assign w_streak_full = (r_streak == SW'(STREAK_MAX));
    assign w_pick_d      = d_req && !(i_req && w_streak_full);

    // Reset forces both waits to follow req, even if the state is still RESP.
    assign w_resp_i = rst_n && (r_state == ST_RESP) && (r_grant == G_INSTR);
    assign w_resp_d = rst_n && (r_state == ST_RESP) && (r_grant == G_DATA);

    assign i_wait  = i_req && !w_resp_i;
    assign d_wait  = d_req && !w_resp_d;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_fault = r_i_fault;
    assign d_fault = r_d_fault;
    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= G_INSTR;
            r_streak  <= '0;
            r_timer   <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_fault <= 1'b0;
            r_d_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        r_state <= ST_BUSY;
                        r_m_req <= 1'b1;
                        r_timer <= '0;
                        if (w_pick_d) begin
                            r_grant   <= G_DATA;
                            r_m_we    <= d_we;
                            r_m_addr  <= d_addr;
                            r_m_wdata <= d_wdata;
                            if (!i_req)
                                r_streak <= '0;
                            else if (!w_streak_full)
                                r_streak <= r_streak + SW'(1);
                        end else begin
                            r_grant  <= G_INSTR;
                            r_m_we   <= 1'b0;
                            r_m_addr <= i_addr;
                            r_streak <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    // An ack in the last allowed cycle still beats the timeout.
                    if (m_ack || (r_timer == TW'(TIMEOUT - 1))) begin
                        r_state <= ST_RESP;
                        r_m_req <= 1'b0;
                        if (r_grant == G_INSTR) begin
                            r_i_rdata <= m_ack ? m_rdata : '0;
                            r_i_fault <= !m_ack;
                        end else begin
                            if (!r_m_we)
                                r_d_rdata <= m_ack ? m_rdata : '0;
                            r_d_fault <= !m_ack;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_RESP: begin
                    r_state   <= ST_IDLE;
                    r_i_fault <= 1'b0;
                    r_d_fault <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, contention order, timeout,
// late ack, write, and reset during a busy transaction.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_wait, i_fault, d_wait, d_fault, m_req, m_we;

    int total = 0;
    int bad   = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_wait(i_wait), .i_fault(i_fault),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_wait(d_wait), .d_fault(d_fault),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for a grant, check who got it, ack at once, check the RESP-cycle waits.
    task automatic do_grant(input string tag, input logic [31:0] exp_addr, input logic is_d);
        int n = 0;
        while (!m_req && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_mreq_seen"}, {31'd0, m_req}, 32'd1);
        chk({tag, "_addr"}, m_addr, exp_addr);
        m_ack   = 1'b1;
        m_rdata = exp_addr + 32'h1;
        step();
        m_ack = 1'b0;
        chk({tag, "_iwait"}, {31'd0, i_wait}, {31'd0, is_d});
        chk({tag, "_dwait"}, {31'd0, d_wait}, {31'd0, !is_d});
        step();
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        step(); step();
        chk("rst_mreq", {31'd0, m_req}, 32'd0);
        chk("rst_mwe", {31'd0, m_we}, 32'd0);
        chk("rst_maddr", m_addr, 32'd0);
        chk("rst_mwdata", m_wdata, 32'd0);
        chk("rst_irdata", i_rdata, 32'd0);
        chk("rst_drdata", d_rdata, 32'd0);
        chk("rst_faults", {30'd0, i_fault, d_fault}, 32'd0);
        i_req = 1'b1;
        #1 chk("rst_iwait_eq_req", {31'd0, i_wait}, 32'd1);
        i_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // single read with ack one cycle after m_req
        i_req = 1'b1; i_addr = 32'h100;
        step();
        chk("rd_mreq", {31'd0, m_req}, 32'd1);
        chk("rd_maddr", m_addr, 32'h100);
        chk("rd_mwe", {31'd0, m_we}, 32'd0);
        chk("rd_iwait_busy", {31'd0, i_wait}, 32'd1);
        m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        step();
        m_ack = 1'b0;
        chk("rd_iwait_resp", {31'd0, i_wait}, 32'd0);
        chk("rd_irdata", i_rdata, 32'hDEADBEEF);
        chk("rd_ifault", {31'd0, i_fault}, 32'd0);
        chk("rd_mreq_resp", {31'd0, m_req}, 32'd0);
        i_req = 1'b0;
        step();
        chk("rd_irdata_hold", i_rdata, 32'hDEADBEEF);

        // contention: D,D,D,D,I,D,D,D,D,I
        i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0;
        for (int g = 0; g < 10; g++) begin
            if (g == 4 || g == 9) do_grant($sformatf("cont%0d", g), 32'h200, 1'b0);
            else                  do_grant($sformatf("cont%0d", g), 32'h300, 1'b1);
        end
        chk("cont_drdata", d_rdata, 32'h301);
        i_req = 1'b0; d_req = 1'b0;
        step();

        // timeout: no ack ever
        d_req = 1'b1; d_addr = 32'h500;
        step();
        cnt = 0;
        while (m_req && cnt < 40) begin
            cnt++;
            step();
        end
        chk("to_busy_cycles", cnt, 32'd16);
        chk("to_dfault", {31'd0, d_fault}, 32'd1);
        chk("to_drdata", d_rdata, 32'd0);
        chk("to_dwait", {31'd0, d_wait}, 32'd0);
        d_req = 1'b0;
        step();
        chk("to_dfault_clr", {31'd0, d_fault}, 32'd0);
        chk("to_idle_mreq", {31'd0, m_req}, 32'd0);

        // late ack in the 16th busy cycle
        i_req = 1'b1; i_addr = 32'h600;
        step();
        for (int k = 0; k < 15; k++) step();
        chk("late_mreq16", {31'd0, m_req}, 32'd1);
        m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
        step();
        m_ack = 1'b0;
        chk("late_ifault", {31'd0, i_fault}, 32'd0);
        chk("late_irdata", i_rdata, 32'hCAFEF00D);
        chk("late_iwait", {31'd0, i_wait}, 32'd0);
        i_req = 1'b0;
        step();
        m_ack = 1'b1; m_rdata = 32'h55555555;
        step();
        chk("spur_mreq0", {31'd0, m_req}, 32'd0);
        step();
        chk("spur_mreq1", {31'd0, m_req}, 32'd0);
        chk("spur_irdata", i_rdata, 32'hCAFEF00D);
        chk("spur_ifault", {31'd0, i_fault}, 32'd0);
        m_ack = 1'b0;
        step();

        // write: bus values stable until ack, d_rdata untouched
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wr_mwe%0d", k), {31'd0, m_we}, 32'd1);
            chk($sformatf("wr_maddr%0d", k), m_addr, 32'h40);
            chk($sformatf("wr_mwdata%0d", k), m_wdata, 32'h1234);
            chk($sformatf("wr_dwait%0d", k), {31'd0, d_wait}, 32'd1);
            if (k < 2) step();
        end
        m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
        step();
        m_ack = 1'b0;
        chk("wr_dwait_resp", {31'd0, d_wait}, 32'd0);
        chk("wr_dfault", {31'd0, d_fault}, 32'd0);
        chk("wr_drdata_keep", d_rdata, 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        step();

        // reset mid-busy: build streak=3, abort, streak must restart from 0
        i_req = 1'b1; i_addr = 32'h700; d_req = 1'b1; d_addr = 32'h800;
        do_grant("pre0", 32'h800, 1'b1);
        do_grant("pre1", 32'h800, 1'b1);
        step();
        chk("rb_busy", {31'd0, m_req}, 32'd1);
        rst_n = 1'b0;
        #1 chk("rb_dwait_in_rst", {31'd0, d_wait}, 32'd1);
        step();
        chk("rb_mreq_low", {31'd0, m_req}, 32'd0);
        chk("rb_maddr_clr", m_addr, 32'd0);
        rst_n = 1'b1;
        chk("rb_no_resp_fault", {31'd0, d_fault}, 32'd0);
        chk("rb_no_resp_wait", {31'd0, d_wait}, 32'd1);
        for (int g = 0; g < 5; g++) begin
            if (g == 4) do_grant($sformatf("post%0d", g), 32'h700, 1'b0);
            else        do_grant($sformatf("post%0d", g), 32'h800, 1'b1);
        end
        i_req = 1'b0; d_req = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
